// File: rtl/ni_packetizer.sv
// ni_packetizer
// Network-interface transmitter for the mesh NoC. Takes a packet request
// (destination, length) plus a stream of data words from the local core and
// emits HEADER / PAYLOAD / TAIL flits into the router's local input port.
// Flow control toward the router is credit based, one credit per flit slot.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   cur_addr_rst node address, captured while rst is high ([1:0]=x, [3:2]=y)
//   req_valid    packet request valid
//   req_ready    request accepted when req_valid & req_ready
//   req_dst      destination node address of the request
//   req_len      number of data words in the packet (0..15)
//   data_valid   data word valid
//   data_ready   data word consumed when data_valid & data_ready
//   data_in      data word
//   flit_valid   one-cycle write strobe into the router FIFO
//   flit_id      HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100
//   flit_dst     destination of the packet, held for all of its flits
//   flit_data    flit payload
//   credit_in    one-cycle pulse, router freed one buffer slot
module ni_packetizer #(
    parameter int DATA_W  = 32,
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cur_addr_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_dst,
    input  logic [3:0]        req_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              flit_valid,
    output logic [2:0]        flit_id,
    output logic [3:0]        flit_dst,
    output logic [DATA_W-1:0] flit_data,
    input  logic              credit_in
);

    localparam logic [2:0] FLIT_HEADER  = 3'b001;
    localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [2:0] FLIT_TAIL    = 3'b100;
    localparam logic [3:0] CREDIT_MAX   = 4'(CREDITS);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        dst_q, dst_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        remaining_q, remaining_d;
    logic              tailPend_q, tailPend_d;
    logic [3:0]        credit_q, credit_d;
    logic [3:0]        curAddr_q;
    logic              flitValid_q, flitValid_d;
    logic [2:0]        flitId_q, flitId_d;
    logic [3:0]        flitDst_q, flitDst_d;
    logic [DATA_W-1:0] flitData_q, flitData_d;
    logic [DATA_W-1:0] headerData;
    logic              hasCredit;
    logic              send;

    // Handshake readies come straight from registered state so the core sees
    // them early in the cycle; both are forced low while reset is applied.
    assign hasCredit  = (credit_q != 4'd0);
    assign req_ready  = (state_q == IDLE) && !rst;
    assign data_ready = (state_q == BODY) && hasCredit && !rst;

    assign flit_valid = flitValid_q;
    assign flit_id    = flitId_q;
    assign flit_dst   = flitDst_q;
    assign flit_data  = flitData_q;

    // Header layout: dst in [3:0], source node in [7:4], length in [11:8].
    always_comb begin
        headerData        = '0;
        headerData[11:0]  = {len_q, curAddr_q, dst_q};
    end

    // Next-state logic. A zero-length packet still needs a TAIL after its
    // HEADER, so HEAD raises tailPend and sends an empty TAIL on the next
    // credited cycle instead of passing through BODY.
    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        tailPend_d  = tailPend_q;
        flitId_d    = flitId_q;
        flitDst_d   = flitDst_q;
        flitData_d  = flitData_q;
        send        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    dst_d      = req_dst;
                    len_d      = req_len;
                    tailPend_d = 1'b0;
                    state_d    = HEAD;
                end
            end
            HEAD: begin
                if (hasCredit) begin
                    send      = 1'b1;
                    flitDst_d = dst_q;
                    if (tailPend_q) begin
                        flitId_d   = FLIT_TAIL;
                        flitData_d = '0;
                        tailPend_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        flitId_d   = FLIT_HEADER;
                        flitData_d = headerData;
                        if (len_q == 4'd0) begin
                            tailPend_d = 1'b1;
                        end else begin
                            remaining_d = len_q;
                            state_d     = BODY;
                        end
                    end
                end
            end
            BODY: begin
                if (data_valid && data_ready) begin
                    send        = 1'b1;
                    flitDst_d   = dst_q;
                    flitData_d  = data_in;
                    remaining_d = remaining_q - 4'd1;
                    if (remaining_q == 4'd1) begin
                        flitId_d = FLIT_TAIL;
                        state_d  = IDLE;
                    end else begin
                        flitId_d = FLIT_PAYLOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A send and a returned credit in the same cycle cancel out; extra
        // credits beyond the router buffer depth are dropped.
        credit_d = credit_q;
        if (send && !credit_in) begin
            credit_d = credit_q - 4'd1;
        end else if (!send && credit_in && (credit_q < CREDIT_MAX)) begin
            credit_d = credit_q + 4'd1;
        end

        flitValid_d = send;
    end

    // State and registered flit outputs. The node address is only captured
    // during reset; a reset mid-packet simply drops the packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dst_q       <= 4'd0;
            len_q       <= 4'd0;
            remaining_q <= 4'd0;
            tailPend_q  <= 1'b0;
            credit_q    <= CREDIT_MAX;
            curAddr_q   <= cur_addr_rst;
            flitValid_q <= 1'b0;
            flitId_q    <= 3'd0;
            flitDst_q   <= 4'd0;
            flitData_q  <= '0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            tailPend_q  <= tailPend_d;
            credit_q    <= credit_d;
            flitValid_q <= flitValid_d;
            flitId_q    <= flitId_d;
            flitDst_q   <= flitDst_d;
            flitData_q  <= flitData_d;
        end
    end

endmodule

// File: tb/tb_ni_packetizer.sv
// Testbench for ni_packetizer: scoreboard of expected flits filled when a
// request is driven and drained by a monitor on the falling clock edge, a
// table of packets run with the router returning credits, and hand-written
// sequences for credit stalls, credit saturation and reset mid-packet.
module tb_ni_packetizer;

    localparam int DATA_W  = 32;
    localparam int CREDITS = 4;

    localparam logic [2:0] ID_HEADER  = 3'b001;
    localparam logic [2:0] ID_PAYLOAD = 3'b010;
    localparam logic [2:0] ID_TAIL    = 3'b100;

    logic              clk;
    logic              rst;
    logic [3:0]        cur_addr_rst;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_dst;
    logic [3:0]        req_len;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data_in;
    logic              flit_valid;
    logic [2:0]        flit_id;
    logic [3:0]        flit_dst;
    logic [DATA_W-1:0] flit_data;
    logic              credit_in;

    typedef struct {
        logic [2:0]  id;
        logic [3:0]  dst;
        logic [31:0] data;
    } flit_t;

    typedef struct {
        logic [3:0]  dst;
        logic [3:0]  len;
        logic [31:0] base;
        logic [31:0] step;
        logic [31:0] expHeader;
        int          expFlits;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    flit_t       sbq[$];
    flit_t       monExp;
    logic [31:0] words[$];
    int          pktFlits;
    int          pktCycles[$];
    int          dataHsCount;
    int          reqEdge;
    bit          autoCredit;
    bit          manualCredit;

    ni_packetizer #(
        .DATA_W  (DATA_W),
        .CREDITS (CREDITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cur_addr_rst (cur_addr_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dst      (req_dst),
        .req_len      (req_len),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_in      (data_in),
        .flit_valid   (flit_valid),
        .flit_id      (flit_id),
        .flit_dst     (flit_dst),
        .flit_data    (flit_data),
        .credit_in    (credit_in)
    );

    // 10 ns clock, rising edge active.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case something wedges the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every flit written to the router must match the head of the
    // scoreboard queue.
    always @(negedge clk) begin
        if (flit_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL flitUnexpected: got id=%0h dst=%0h data=0x%0h, expected no flit (cycle %0d)",
                         flit_id, flit_dst, flit_data, cycle);
            end else begin
                monExp = sbq.pop_front();
                checkOutput("flit", 64'({flit_id, flit_dst, flit_data}),
                            64'({monExp.id, monExp.dst, monExp.data}));
            end
        end
    end

    // One clock: capture handshakes seen before the edge, then update the
    // core-side data stream and the router-side credit return after it.
    task automatic tick();
        bit dataHs;
        bit reqHs;
        dataHs = ((data_valid && data_ready) === 1'b1);
        reqHs  = ((req_valid && req_ready) === 1'b1);
        @(posedge clk);
        #1;
        if (reqHs) begin
            req_valid = 1'b0;
            reqEdge   = cycle;
        end
        if (dataHs) begin
            if (words.size() != 0) void'(words.pop_front());
            dataHsCount++;
        end
        data_valid = (words.size() != 0);
        data_in    = (words.size() != 0) ? words[0] : '0;
        if (flit_valid === 1'b1) begin
            pktFlits++;
            pktCycles.push_back(cycle);
        end
        credit_in = (autoCredit && (flit_valid === 1'b1)) || manualCredit;
    endtask

    // Loads the data words, pushes up to 'limit' expected flits and raises
    // the request.
    task automatic applyStimulus(input logic [3:0] dst, input logic [3:0] len, input logic [31:0] base,
                                 input logic [31:0] step, input logic [31:0] expHeader, input int limit);
        flit_t       e;
        int          pushed;
        logic [31:0] w;
        pushed = 0;
        words.delete();
        for (int i = 0; i < int'(len); i++) begin
            w = base + step * 32'(i);
            words.push_back(w);
        end
        data_valid = (words.size() != 0);
        data_in    = (words.size() != 0) ? words[0] : '0;
        e = '{id: ID_HEADER, dst: dst, data: expHeader};
        if (pushed < limit) begin sbq.push_back(e); pushed++; end
        if (len == 4'd0) begin
            e = '{id: ID_TAIL, dst: dst, data: 32'h0};
            if (pushed < limit) begin sbq.push_back(e); pushed++; end
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                e = '{id: (i == int'(len) - 1) ? ID_TAIL : ID_PAYLOAD, dst: dst, data: words[i]};
                if (pushed < limit) begin sbq.push_back(e); pushed++; end
            end
        end
        pktFlits    = 0;
        pktCycles.delete();
        dataHsCount = 0;
        reqEdge     = -1;
        req_dst     = dst;
        req_len     = len;
        req_valid   = 1'b1;
    endtask

    task automatic waitAccept();
        for (int i = 0; i < 10 && reqEdge < 0; i++) tick();
        checkOutput("reqAccepted", 64'(reqEdge >= 0), 64'd1);
    endtask

    task automatic waitReady(output int readyCycle);
        readyCycle = -1;
        for (int i = 0; i < 60 && readyCycle < 0; i++) begin
            tick();
            if (req_ready === 1'b1) readyCycle = cycle;
        end
    endtask

    // Full packet with credits never running out: checks count, latency,
    // back-to-back spacing, return of req_ready and number of words taken.
    task automatic runPacket(input vec_t v);
        int readyCycle;
        int badGap;
        applyStimulus(v.dst, v.len, v.base, v.step, v.expHeader, 99);
        waitAccept();
        waitReady(readyCycle);
        tick();
        badGap = 0;
        foreach (pktCycles[i]) if (pktCycles[i] != reqEdge + 1 + i) badGap++;
        checkOutput("flitCount", 64'(pktFlits), 64'(v.expFlits));
        checkOutput("hdrLatency", 64'((pktCycles.size() != 0) ? pktCycles[0] - reqEdge : -1), 64'd1);
        checkOutput("burst", 64'(badGap), 64'd0);
        checkOutput("readyBack", 64'(readyCycle - reqEdge), 64'(v.expFlits));
        checkOutput("dataTaken", 64'(dataHsCount), 64'(v.len));
    endtask

    // Packet sent without credit return: must stall after expStall flits.
    task automatic limitedPacket(input logic [3:0] dst, input logic [3:0] len, input logic [31:0] base,
                                 input logic [31:0] expHeader, input int expStall);
        applyStimulus(dst, len, base, 32'h1, expHeader, 99);
        waitAccept();
        repeat (12) tick();
        checkOutput("stallFlits", 64'(pktFlits), 64'(expStall));
        checkOutput("stallDataReady", 64'(data_ready), 64'd0);
        checkOutput("stallReqReady", 64'(req_ready), 64'd0);
    endtask

    task automatic pulseCredits(input int n);
        manualCredit = 1'b1;
        repeat (n) tick();
        manualCredit = 1'b0;
        tick();
    endtask

    task automatic finishPacket(input int n, input int expTotal);
        int readyCycle;
        pulseCredits(n);
        waitReady(readyCycle);
        tick();
        checkOutput("finishFlits", 64'(pktFlits), 64'(expTotal));
        checkOutput("finishReady", 64'(readyCycle >= 0), 64'd1);
    endtask

    task automatic checkReset();
        checkOutput("rstFlitValid", 64'(flit_valid), 64'd0);
        checkOutput("rstFlitId", 64'(flit_id), 64'd0);
        checkOutput("rstFlitDst", 64'(flit_dst), 64'd0);
        checkOutput("rstFlitData", 64'(flit_data), 64'd0);
        checkOutput("rstReqReady", 64'(req_ready), 64'd0);
        checkOutput("rstDataReady", 64'(data_ready), 64'd0);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t zeroVec;
        vecs[0] = '{dst: 4'hA, len: 4'd3,  base: 32'h11,        step: 32'h11,      expHeader: 32'h35A, expFlits: 4};
        vecs[1] = '{dst: 4'h0, len: 4'd1,  base: 32'hDEADBEEF,  step: 32'h1,       expHeader: 32'h150, expFlits: 2};
        vecs[2] = '{dst: 4'hF, len: 4'd15, base: 32'h10000000,  step: 32'h01010101, expHeader: 32'hF5F, expFlits: 16};
        vecs[3] = '{dst: 4'h3, len: 4'd0,  base: 32'h0,         step: 32'h0,       expHeader: 32'h053, expFlits: 2};
        vecs[4] = '{dst: 4'hC, len: 4'd2,  base: 32'hFFFFFFFE,  step: 32'h1,       expHeader: 32'h25C, expFlits: 3};
        zeroVec = '{dst: 4'h1, len: 4'd0,  base: 32'h0,         step: 32'h0,       expHeader: 32'h051, expFlits: 2};

        rst          = 1'b1;
        cur_addr_rst = 4'h5;
        req_valid    = 1'b0;
        req_dst      = 4'h0;
        req_len      = 4'h0;
        data_valid   = 1'b0;
        data_in      = '0;
        credit_in    = 1'b0;
        autoCredit   = 1'b0;
        manualCredit = 1'b0;
        pktFlits     = 0;
        dataHsCount  = 0;
        reqEdge      = -1;

        // Reset held for two cycles, then released; node address changes
        // afterwards and must not leak into headers.
        tick();
        tick();
        checkReset();
        rst          = 1'b0;
        cur_addr_rst = 4'h9;
        #1;
        checkOutput("readyAfterReset", 64'(req_ready), 64'd1);

        $display("[TB] table packets with credit return");
        autoCredit = 1'b1;
        foreach (vecs[i]) runPacket(vecs[i]);

        $display("[TB] credit stall");
        autoCredit = 1'b0;
        runPacket(zeroVec);
        limitedPacket(4'h6, 4'd4, 32'hA0, 32'h456, 2);
        pulseCredits(1);
        repeat (4) tick();
        checkOutput("oneCreditFlits", 64'(pktFlits), 64'd3);
        finishPacket(2, 5);

        $display("[TB] credit saturation");
        pulseCredits(4);
        pulseCredits(3);
        limitedPacket(4'h2, 4'd8, 32'hB00, 32'h852, 4);
        finishPacket(5, 9);

        $display("[TB] reset mid-packet");
        pulseCredits(4);
        autoCredit = 1'b1;
        applyStimulus(4'h7, 4'd5, 32'h5000, 32'h1, 32'h557, 2);
        waitAccept();
        for (int i = 0; i < 10 && pktFlits < 2; i++) tick();
        checkOutput("midFlits", 64'(pktFlits), 64'd2);
        rst          = 1'b1;
        cur_addr_rst = 4'h5;
        autoCredit   = 1'b0;
        credit_in    = 1'b0;
        tick();
        tick();
        checkReset();
        rst          = 1'b0;
        cur_addr_rst = 4'h9;
        words.delete();
        data_valid   = 1'b0;
        tick();
        tick();
        checkOutput("noTailAfterReset", 64'(pktFlits), 64'd2);
        limitedPacket(4'h4, 4'd8, 32'hC00, 32'h854, 4);
        finishPacket(5, 9);

        checkOutput("sbDrained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Network-interface transmitter for the mesh NoC. Accepts a packet request (destination, length) and a stream of data words from the local core. Emits the flit stream (HEADER, PAYLOAD, TAIL) that the router's local input port buffers and that the LBDR routing stage consumes. Flow control toward the router is credit-based, one credit per flit buffer slot.

## Interface
Parameters:
- DATA_W, default 32: flit payload width in bits; must be at least 12.
- CREDITS, default 4: router local-port buffer depth, which is the initial credit count (1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- cur_addr_rst  input  4  node address, latched while rst=1; [1:0] is x, [3:2] is y.
- req_valid  input  1  packet request valid.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_dst  input  4  destination node address.
- req_len  input  4  number of data words in the packet (0..15).
- data_valid  input  1  data word valid.
- data_ready  output  1  data word consumed when data_valid & data_ready.
- data_in  input  DATA_W  data word.
- flit_valid  output  1  flit present this cycle; a single-cycle write strobe into the router FIFO.
- flit_id  output  3  `HEADER=3'b001, `PAYLOAD=3'b010, `TAIL=3'b100 (shared parameter include).
- flit_dst  output  4  destination address of the current packet, held for every flit of the packet.
- flit_data  output  DATA_W  flit payload.
- credit_in  input  1  one-cycle pulse: router freed one buffer slot.

## Operation
- **State machine:** IDLE, HEAD, BODY.
- **IDLE**
  - req_ready=1.
  - On request handshake, latch req_dst and req_len, then go to HEAD.
- **HEAD**
  - When credit_cnt != 0, send the header flit.
  - Header flit_data: [3:0]=dst, [7:4]=cur_addr, [11:8]=len, upper bits 0.
  - If len=0, go directly to a zero-data TAIL send (a pending-tail flag), then IDLE.
  - Otherwise go to BODY with remaining=len.
- **BODY**
  - data_ready = (credit_cnt != 0). This is combinational from registered state.
  - Each data handshake sends a flit with flit_data=data_in.
  - flit_id is `PAYLOAD while remaining>1, and `TAIL when remaining=1.
  - remaining decrements on each send; after the TAIL send, go to IDLE.
- **Flit sequence:** a packet is always exactly 1 HEADER, then max(len,1)-1 PAYLOAD, then 1 TAIL.
- **Credits:** credit_cnt is a 4-bit counter.
  - Decrements on a send.
  - Increments on credit_in.
  - Unchanged when a send and credit_in occur in the same cycle.
  - Saturates at CREDITS, so an excess credit_in is ignored.
  - Never sends when the count is 0.
- **Invariants:**
  - req_ready=0 and data_ready=0 outside their states.
  - data is never consumed in IDLE or HEAD.
  - A new request is not accepted until the TAIL has been sent.

## Timing
- **Reset** (rst=1 at a clock edge):
  - state=IDLE, credit_cnt=CREDITS, cur_addr=cur_addr_rst.
  - flit_valid=0, flit_id=0, flit_dst=0, flit_data=0.
  - req_ready=0 and data_ready=0 during rst.
  - Reset mid-packet abandons the packet; no TAIL is emitted.
- **Output timing:** flit outputs are registered. A send decided in cycle t gives flit_valid=1 in cycle t+1 with its flit_id, flit_dst and flit_data. flit_valid is low in any cycle without a send in the previous cycle; the other flit outputs hold their last value.
- **Latencies:**
  - Request handshake at t: header sent at t+1 (registered visible t+2) if credits are available.
  - Back-to-back flits at 1 flit/cycle while credits and data are available.
  - Minimum packet with len=0: HEADER at t+2, TAIL at t+3, req_ready high again at t+3.
- **Stalls:**
  - Credits exhausted: the FSM stalls in HEAD or BODY; data_ready drops in the same cycle credit_cnt reaches 0.
  - A credit_in while the count is 0 allows a send in the following cycle.

## Test plan
- **Reset:** CREDITS=4, cur_addr_rst=4'h5, rst high 2 cycles -> all outputs 0, req_ready=0; after release, req_ready=1.
- **3-word packet:** req_dst=4'hA, req_len=3, data 11,22,33 always valid, credit_in pulsed each flit -> flits HEADER (data 0x35A, dst A), PAYLOAD 11, PAYLOAD 22, TAIL 33 on consecutive cycles; flit_dst=A on all.
- **Zero-length packet:** req_len=0 -> exactly HEADER then TAIL with data 0; no data handshake; req_ready back at t+3.
- **Credit stall:** CREDITS=2, len=4, no credit_in -> only HEADER and PAYLOAD sent, then data_ready=0. One credit_in -> exactly one more PAYLOAD.
- **Simultaneous send and credit_in, plus saturation:** simultaneous send and credit_in -> count unchanged. 3 extra credit_in pulses at full credit -> count stays 4.
- **Reset mid-BODY:** after the 2nd flit, rst asserted -> no TAIL emitted; next packet starts cleanly with HEADER and credit_cnt=CREDITS.
